wrp_shff_blk_sched: RTL and testbench
=====================================

// Module: wrp_shff_blk_sched
// PURPOSE
//  Block-level scheduler for the shuffle buffer (URAM, 16-word blocks).
//  Tracks block occupancy between the shuffle-network writer and the FIFO-out reader.
//  Issues write/read block pointers, buf_empty and wr_ready, and the transpose-phase bit.
//  Sequences prefill, run and flush-drain phases.
// PARAMETERS
//  BLK_AW      10    block address width; NUM_BLK = 2**BLK_AW blocks
//  PREFILL     32    blocks that must be written before reads open (FILL -> RUN)
//  WR_SLACK    2     wr_ready deasserts when occupancy >= NUM_BLK-WR_SLACK
//  FRAME_BLKS  1024  blocks read per frame; frame_parity toggles after each frame
// PORTS
//  clk           in   1         clock
//  srst          in   1         synchronous reset, active-high
//  wr_blk_done   in   1         pulse: writer completed one 16-word block
//  wr_ready      out  1         writer may start another block
//  wr_blk_ptr    out  BLK_AW    block index the writer fills next
//  rd_blk_start  in   1         pulse: reader consumed one block (read session start)
//  buf_empty     out  1         no readable block
//  rd_blk_ptr    out  BLK_AW    block index the reader reads next
//  frame_parity  out  1         transpose phase of the block at rd_blk_ptr
//  flush         in   1         pulse: drain all stored blocks
//  flush_done    out  1         one-cycle pulse: drain complete
//  occupancy     out  BLK_AW+1  stored block count, 0..NUM_BLK
//  err_ovf       out  1         sticky overflow flag (SHFF_SCHED_ERR_EN only)
//  err_udf       out  1         sticky underflow flag (SHFF_SCHED_ERR_EN only)
// BEHAVIOUR
//  - All outputs registered. Reset values: wr_ready=0, buf_empty=1, pointers=0,
//    occupancy=0, frame_parity=0, flush_done=0, err_*=0.
//  - FSM: RST -> FILL (one cycle after srst drops).
//    FILL -> RUN when occupancy >= PREFILL.
//    FILL/RUN -> DRAIN on flush.
//    DRAIN -> FILL when occupancy==0; flush_done pulses on that transition.
//  - buf_empty = (state==FILL) | (occupancy==0). It updates the cycle after the
//    input event (1-cycle latency).
//  - wr_ready = (state!=RST) & (state!=DRAIN) & (occupancy < NUM_BLK-WR_SLACK).
//  - Accepted wr_blk_done: wr_blk_ptr+1 (wraps at NUM_BLK), occupancy+1.
//  - Accepted rd_blk_start: rd_blk_ptr+1 (wraps), occupancy-1, rd frame counter+1.
//    When the frame counter reaches FRAME_BLKS-1 it wraps to 0 and frame_parity toggles.
//  - Simultaneous accepted write and read: both pointers advance, occupancy unchanged.
//  - wr_blk_done with occupancy==NUM_BLK: dropped; no pointer or count change.
//  - rd_blk_start with occupancy==0, or in FILL: ignored.
//  - wr_blk_done in DRAIN is still accepted if not full, which extends the drain.
//  - flush while already in DRAIN: no effect.
//  - flush when occupancy==0: DRAIN is entered, then FILL on the next cycle,
//    with flush_done pulsed.
//  - srst mid-operation: all state returns to reset values on the next edge.
//    In-flight blocks are discarded.
// CONFIGURATION
//  - Macro SHFF_SCHED_ERR_EN defined:
//    err_ovf sets on a dropped write; err_udf sets on an ignored read
//    (empty or FILL). Both flags clear only on srst.
//  - Macro undefined: err_ovf/err_udf are tied to 0 and no detection logic is built.
// STRUCTURE
//  - Package wrp_shff_pkg: FSM state encodings (RST/FILL/RUN/DRAIN) and default
//    BLK_AW/PREFILL/FRAME_BLKS constants, shared with the shuffle writer and FIFO-out.
//  - Sub-module wrp_shff_ptr_ctr: wrapping BLK_AW-bit pointer with enable and
//    synchronous clear. Instantiated twice (write pointer, read pointer).
// TESTING
//  1. Reset/prefill: srst, then 31 writes -> buf_empty=1, occupancy=31.
//     32nd write -> buf_empty=0 one cycle later, state RUN.
//  2. Simultaneous: occupancy=5, wr_blk_done and rd_blk_start in the same cycle
//     -> occupancy stays 5, both pointers +1.
//  3. Full: fill to 1022 -> wr_ready=0. Write to 1024, then one more write
//     -> dropped, wr_blk_ptr unchanged, err_ovf=1 (macro defined).
//  4. Wrap/frame: 1024 reads -> rd_blk_ptr wraps 1023->0.
//     frame_parity toggles exactly after the 1024th read.
//  5. Flush: occupancy=3, flush -> wr_ready=0. Three reads -> flush_done pulses once,
//     state FILL, buf_empty=1.
//  6. Reset mid-run: occupancy=40, srst for one cycle -> all outputs at reset values
//     the next cycle.

Source files
------------

// File: rtl/wrp_shff_pkg.sv
// Shared definitions for the shuffle-buffer block scheduler, writer and FIFO-out.
package wrp_shff_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } shff_state_e;

  localparam int SHFF_BLK_AW     = 10;
  localparam int SHFF_PREFILL    = 32;
  localparam int SHFF_WR_SLACK   = 2;
  localparam int SHFF_FRAME_BLKS = 1024;

endpackage

// File: rtl/wrp_shff_ptr_ctr.sv
// Wrapping block pointer with count enable and synchronous clear.
module wrp_shff_ptr_ctr
  import wrp_shff_pkg::*;
#(
  parameter int AW = SHFF_BLK_AW
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [AW-1:0] ptr_o
);

  logic [AW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/wrp_shff_blk_sched.sv
// Block-level scheduler for the URAM shuffle buffer: occupancy, pointers, phases.
// Define SHFF_SCHED_ERR_EN to build the sticky overflow/underflow flags.
module wrp_shff_blk_sched
  import wrp_shff_pkg::*;
#(
  parameter int BLK_AW     = SHFF_BLK_AW,
  parameter int PREFILL    = SHFF_PREFILL,
  parameter int WR_SLACK   = SHFF_WR_SLACK,
  parameter int FRAME_BLKS = SHFF_FRAME_BLKS
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              wr_blk_done,
  output logic              wr_ready,
  output logic [BLK_AW-1:0] wr_blk_ptr,
  input  logic              rd_blk_start,
  output logic              buf_empty,
  output logic [BLK_AW-1:0] rd_blk_ptr,
  output logic              frame_parity,
  input  logic              flush,
  output logic              flush_done,
  output logic [BLK_AW:0]   occupancy,
  output logic              err_ovf,
  output logic              err_udf
);

  localparam int NUM_BLK = 1 << BLK_AW;
  localparam int FC_W    = (FRAME_BLKS > 1) ? $clog2(FRAME_BLKS) : 1;

  localparam logic [BLK_AW:0] OCC_FULL = (BLK_AW+1)'(NUM_BLK);
  localparam logic [BLK_AW:0] OCC_HI   = (BLK_AW+1)'(NUM_BLK - WR_SLACK);
  localparam logic [BLK_AW:0] OCC_PRE  = (BLK_AW+1)'(PREFILL);
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FRAME_BLKS - 1);

  shff_state_e     state_q, state_d;
  logic [BLK_AW:0] occ_q, occ_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic            par_q, par_d;
  logic            wr_ready_q, wr_ready_d;
  logic            buf_empty_q, buf_empty_d;
  logic            flush_done_q, flush_done_d;
  logic            wr_acc, rd_acc;

  // Writes are taken in any live state until the buffer is truly full; the
  // wr_ready slack only covers the writer's reaction latency.
  assign wr_acc = wr_blk_done && (state_q != ST_RST) && (occ_q != OCC_FULL);
  assign rd_acc = rd_blk_start && ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                  (occ_q != '0);

  always_comb begin
    occ_d = occ_q;
    if (wr_acc && !rd_acc)      occ_d = occ_q + 1'b1;
    else if (rd_acc && !wr_acc) occ_d = occ_q - 1'b1;
  end

  // Phase decisions look at next-cycle occupancy so state, count and flags move together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:   state_d = ST_FILL;
      ST_FILL: begin
        if (flush)                 state_d = ST_DRAIN;
        else if (occ_d >= OCC_PRE) state_d = ST_RUN;
      end
      ST_RUN:   if (flush) state_d = ST_DRAIN;
      ST_DRAIN: if (occ_d == '0) state_d = ST_FILL;
      default:  state_d = ST_RST;
    endcase
  end

  always_comb begin
    fc_d  = fc_q;
    par_d = par_q;
    if (rd_acc) begin
      if (fc_q == FC_LAST) begin
        fc_d  = '0;
        par_d = ~par_q;
      end else begin
        fc_d  = fc_q + 1'b1;
      end
    end
    wr_ready_d   = (state_d != ST_RST) && (state_d != ST_DRAIN) && (occ_d < OCC_HI);
    buf_empty_d  = (state_d == ST_FILL) || (occ_d == '0);
    flush_done_d = (state_q == ST_DRAIN) && (state_d == ST_FILL);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= ST_RST;
      occ_q        <= '0;
      fc_q         <= '0;
      par_q        <= 1'b0;
      wr_ready_q   <= 1'b0;
      buf_empty_q  <= 1'b1;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      fc_q         <= fc_d;
      par_q        <= par_d;
      wr_ready_q   <= wr_ready_d;
      buf_empty_q  <= buf_empty_d;
      flush_done_q <= flush_done_d;
    end
  end

  wrp_shff_ptr_ctr #(.AW(BLK_AW)) u_wr_ptr (
    .clk   (clk),
    .clr_i (srst),
    .en_i  (wr_acc),
    .ptr_o (wr_blk_ptr)
  );

  wrp_shff_ptr_ctr #(.AW(BLK_AW)) u_rd_ptr (
    .clk   (clk),
    .clr_i (srst),
    .en_i  (rd_acc),
    .ptr_o (rd_blk_ptr)
  );

`ifdef SHFF_SCHED_ERR_EN
  logic err_ovf_q, err_udf_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      if (wr_blk_done && (state_q != ST_RST) && (occ_q == OCC_FULL)) err_ovf_q <= 1'b1;
      if (rd_blk_start && (state_q != ST_RST) && !rd_acc)            err_udf_q <= 1'b1;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif

  assign wr_ready     = wr_ready_q;
  assign buf_empty    = buf_empty_q;
  assign frame_parity = par_q;
  assign flush_done   = flush_done_q;
  assign occupancy    = occ_q;

endmodule

// File: tb/tb_wrp_shff_blk_sched.sv
// Directed bench for wrp_shff_blk_sched with hand-computed expectations.
module tb_wrp_shff_blk_sched;

  logic        clk = 1'b0;
  logic        srst;
  logic        wr_blk_done;
  logic        wr_ready;
  logic [9:0]  wr_blk_ptr;
  logic        rd_blk_start;
  logic        buf_empty;
  logic [9:0]  rd_blk_ptr;
  logic        frame_parity;
  logic        flush;
  logic        flush_done;
  logic [10:0] occupancy;
  logic        err_ovf;
  logic        err_udf;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SHFF_SCHED_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  wrp_shff_blk_sched dut (
    .clk          (clk),
    .srst         (srst),
    .wr_blk_done  (wr_blk_done),
    .wr_ready     (wr_ready),
    .wr_blk_ptr   (wr_blk_ptr),
    .rd_blk_start (rd_blk_start),
    .buf_empty    (buf_empty),
    .rd_blk_ptr   (rd_blk_ptr),
    .frame_parity (frame_parity),
    .flush        (flush),
    .flush_done   (flush_done),
    .occupancy    (occupancy),
    .err_ovf      (err_ovf),
    .err_udf      (err_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic w, input logic r, input logic f);
    wr_blk_done  = w;
    rd_blk_start = r;
    flush        = f;
    tick();
    wr_blk_done  = 1'b0;
    rd_blk_start = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".wr_ready"},     32'(wr_ready),     32'd0);
    chk({tag, ".buf_empty"},    32'(buf_empty),    32'd1);
    chk({tag, ".wr_blk_ptr"},   32'(wr_blk_ptr),   32'd0);
    chk({tag, ".rd_blk_ptr"},   32'(rd_blk_ptr),   32'd0);
    chk({tag, ".occupancy"},    32'(occupancy),    32'd0);
    chk({tag, ".frame_parity"}, 32'(frame_parity), 32'd0);
    chk({tag, ".flush_done"},   32'(flush_done),   32'd0);
    chk({tag, ".err_ovf"},      32'(err_ovf),      32'd0);
    chk({tag, ".err_udf"},      32'(err_udf),      32'd0);
  endtask

  initial begin
    srst = 1'b1; wr_blk_done = 1'b0; rd_blk_start = 1'b0; flush = 1'b0;
    tick(); tick(); tick();
    chk_reset_vals("rst");

    srst = 1'b0;
    tick();
    chk("fill.wr_ready",  32'(wr_ready),  32'd1);
    chk("fill.buf_empty", 32'(buf_empty), 32'd1);

    // Prefill: 31 writes keep reads closed
    for (int i = 0; i < 31; i++) pulse(1'b1, 1'b0, 1'b0);
    chk("pre31.occ",       32'(occupancy),  32'd31);
    chk("pre31.buf_empty", 32'(buf_empty),  32'd1);
    chk("pre31.wr_ptr",    32'(wr_blk_ptr), 32'd31);
    pulse(1'b0, 1'b1, 1'b0);
    chk("fillrd.occ",     32'(occupancy),  32'd31);
    chk("fillrd.rd_ptr",  32'(rd_blk_ptr), 32'd0);
    chk("fillrd.err_udf", 32'(err_udf),    32'(ERR_ON));
    pulse(1'b1, 1'b0, 1'b0);
    chk("pre32.occ",       32'(occupancy), 32'd32);
    chk("pre32.buf_empty", 32'(buf_empty), 32'd0);
    chk("pre32.wr_ready",  32'(wr_ready),  32'd1);

    // Drain to 5, then simultaneous write+read
    for (int i = 0; i < 27; i++) pulse(1'b0, 1'b1, 1'b0);
    chk("occ5.occ",    32'(occupancy),  32'd5);
    chk("occ5.rd_ptr", 32'(rd_blk_ptr), 32'd27);
    pulse(1'b1, 1'b1, 1'b0);
    chk("simul.occ",    32'(occupancy),  32'd5);
    chk("simul.wr_ptr", 32'(wr_blk_ptr), 32'd33);
    chk("simul.rd_ptr", 32'(rd_blk_ptr), 32'd28);

    // Full boundary
    for (int i = 0; i < 1016; i++) pulse(1'b1, 1'b0, 1'b0);
    chk("occ1021.occ",      32'(occupancy), 32'd1021);
    chk("occ1021.wr_ready", 32'(wr_ready),  32'd1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("occ1022.occ",      32'(occupancy), 32'd1022);
    chk("occ1022.wr_ready", 32'(wr_ready),  32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("full.occ",     32'(occupancy),  32'd1024);
    chk("full.wr_ptr",  32'(wr_blk_ptr), 32'd28);
    chk("full.err_ovf", 32'(err_ovf),    32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("drop.occ",     32'(occupancy),  32'd1024);
    chk("drop.wr_ptr",  32'(wr_blk_ptr), 32'd28);
    chk("drop.err_ovf", 32'(err_ovf),    32'(ERR_ON));

    // Pointer wrap and frame parity (28 reads already done)
    for (int i = 0; i < 995; i++) pulse(1'b0, 1'b1, 1'b0);
    chk("rd1023.rd_ptr", 32'(rd_blk_ptr),   32'd1023);
    chk("rd1023.parity", 32'(frame_parity), 32'd0);
    chk("rd1023.occ",    32'(occupancy),    32'd29);
    pulse(1'b0, 1'b1, 1'b0);
    chk("rd1024.rd_ptr", 32'(rd_blk_ptr),   32'd0);
    chk("rd1024.parity", 32'(frame_parity), 32'd1);
    chk("rd1024.occ",    32'(occupancy),    32'd28);
    for (int i = 0; i < 28; i++) pulse(1'b0, 1'b1, 1'b0);
    chk("empty.occ",       32'(occupancy),  32'd0);
    chk("empty.buf_empty", 32'(buf_empty),  32'd1);
    pulse(1'b0, 1'b1, 1'b0);
    chk("udf.rd_ptr", 32'(rd_blk_ptr), 32'd28);
    chk("udf.occ",    32'(occupancy),  32'd0);

    // Flush with three stored blocks
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0);
    chk("fl.occ",    32'(occupancy),  32'd3);
    chk("fl.wr_ptr", 32'(wr_blk_ptr), 32'd31);
    pulse(1'b0, 1'b0, 1'b1);
    chk("fl.wr_ready",   32'(wr_ready),   32'd0);
    chk("fl.flush_done", 32'(flush_done), 32'd0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("fl2.flush_done", 32'(flush_done), 32'd0);
    chk("fl2.wr_ready",   32'(wr_ready),   32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("dr2.occ",        32'(occupancy),  32'd1);
    chk("dr2.flush_done", 32'(flush_done), 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("dr3.occ",        32'(occupancy),  32'd0);
    chk("dr3.flush_done", 32'(flush_done), 32'd1);
    chk("dr3.buf_empty",  32'(buf_empty),  32'd1);
    chk("dr3.wr_ready",   32'(wr_ready),   32'd1);
    chk("dr3.rd_ptr",     32'(rd_blk_ptr), 32'd31);
    tick();
    chk("dr4.flush_done", 32'(flush_done), 32'd0);

    // Flush on an empty buffer: one DRAIN cycle then back to FILL
    pulse(1'b0, 1'b0, 1'b1);
    chk("fe.wr_ready",   32'(wr_ready),   32'd0);
    chk("fe.flush_done", 32'(flush_done), 32'd0);
    tick();
    chk("fe2.flush_done", 32'(flush_done), 32'd1);
    chk("fe2.wr_ready",   32'(wr_ready),   32'd1);
    tick();
    chk("fe3.flush_done", 32'(flush_done), 32'd0);

    // Reset in the middle of a run
    for (int i = 0; i < 40; i++) pulse(1'b1, 1'b0, 1'b0);
    chk("r40.occ",       32'(occupancy), 32'd40);
    chk("r40.buf_empty", 32'(buf_empty), 32'd0);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk_reset_vals("midrst");
    tick();
    chk("midrst2.wr_ready", 32'(wr_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
